serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Receive-side counterpart of the 8-bit bidirectional shift register. That register serializes a word onto a single bit line; this block collects those bits back into a parallel word.
- Samples one serial bit per strobe. Shifts it in at the end selected by `dir` and assembles a WIDTH-bit word.
- Hands the word to downstream logic through a double-buffered valid/ack holding register, with sticky overrun reporting.

Parameters:
- WIDTH, 8: data bits per frame; legal range 2..32.
- CNT_W, $clog2(WIDTH+1): width of the internal bit counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- si  input  1  serial data bit, sampled only when sv=1
- sv  input  1  bit strobe; one bit accepted per clk edge with sv=1
- dir  input  1  0: bit enters at bit 0 and moves toward the MSB, so the first bit ends in bit WIDTH-1; 1: bit enters at bit WIDTH-1 and moves toward the LSB, so the first bit ends in bit 0. Sampled per bit.
- start  input  1  synchronous frame restart; discards the partial frame
- q  output  WIDTH  holding register, valid while q_valid=1
- q_valid  output  1  holding register contains an unconsumed word
- q_ack  input  1  consumer takes q; effective only when q_valid=1
- busy  output  1  a frame is partially received (state not IDLE)
- ovr  output  1  sticky overrun flag
- clr_ovr  input  1  clears ovr
- perr  output  1  sticky parity error; tied 0 without PARITY_CHECK_EN

Behaviour:
- Reset (asynchronous, any state):
  - q=0, q_valid=0, ovr=0, perr=0, busy=0.
  - Shift register cleared, counter=0, state=IDLE.
  - Reset mid-frame discards all partial bits.
- Storage:
  - Internal shift register `sr` (WIDTH bits) and counter `cnt` (CNT_W bits).
  - Separate output register q, so the next frame can be received while q is held.
- FSM states: IDLE, SHIFT, PAR (PAR only with the macro).
- IDLE, sv=1: shift si into sr, cnt=1, go to SHIFT.
- SHIFT, sv=1 and cnt<WIDTH-1: shift, cnt++.
- SHIFT, sv=1 and cnt==WIDTH-1: this is the final bit.
  - Shift it in.
  - Without the macro: commit the word (see below), cnt=0, go to IDLE.
- sv=0: hold state, sr and cnt; gaps of any length are legal.
- Commit, latency: q and q_valid update on the clk edge that samples the WIDTH-th strobe, i.e. visible in the following cycle. q receives the post-shift value of sr.
- Commit, collision cases:
  - q_valid=0: q=word, q_valid=1.
  - q_valid=1 and q_ack=1 in the same cycle: q=word, q_valid stays 1, no overrun.
  - q_valid=1 and q_ack=0: word dropped, q keeps the old word, ovr=1.
- q_ack with no commit in that cycle: q_valid=0; q retains its value.
- q_ack while q_valid=0: ignored.
- start:
  - Forces cnt=0 and state=IDLE; q, q_valid and flags are unaffected.
  - If sv=1 in the same cycle, that bit is the first bit of the new frame: state=SHIFT, cnt=1, sr holds only that bit.
  - start has priority over frame completion: the final-bit cycle plus start produces no commit.
- clr_ovr:
  - Clears ovr.
  - If an overrun occurs in the same cycle, ovr stays 1 (set wins).
  - Also clears perr when the macro is defined.
- busy = (state != IDLE).

Optional Feature:
- Macro: PARITY_CHECK_EN
- Defined:
  - On the final data bit, SHIFT goes to PAR instead of committing.
  - In PAR, the next sv bit is the parity bit. Even parity: XOR of the WIDTH data bits and the parity bit must be 0.
  - Pass: commit as above, go to IDLE.
  - Fail: word discarded, perr=1 (sticky until clr_ovr or rst), go to IDLE, q and q_valid untouched.
  - start in PAR returns to IDLE without a commit.
  - busy=1 in PAR.
- Undefined: no PAR state; perr is constant 0; a frame is exactly WIDTH bits.

Test Plan:
- Reset: assert rst asynchronously mid-frame after 3 bits -> q=0, q_valid=0, busy=0, ovr=0 immediately. The next 8 bits form a clean frame.
- dir=0, bits 1,0,1,1,0,0,1,0 on consecutive strobes -> q=8'hB2, q_valid=1 in the cycle after the 8th strobe, busy=0. Same bits with dir=1 -> q=8'h4D.
- Same B2 frame with 0-5 idle cycles between strobes -> identical q=8'hB2. busy=1 from the first bit until the commit.
- Overrun: frame 8'h11 unacked, then frame 8'h22 -> q=8'h11, ovr=1. Then q_ack -> q_valid=0. clr_ovr -> ovr=0. Frame 8'h33 completed with q_ack asserted in the commit cycle -> q=8'h33, q_valid=1, ovr=0.
- start after 3 bits, then 8 one-bits (dir=0) -> q=8'hFF; the stale bits never appear. start coincident with the 8th bit -> no commit, busy=1, cnt=1.
- PARITY_CHECK_EN, data 8'hA5 with parity bit 0 -> q=8'hA5, perr=0. Data 8'hA5 with parity bit 1 -> q_valid unchanged, perr=1.

Source files
------------

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH strobed bits into a word and hands it over via a valid/ack holding register.
// Optional even-parity check on a trailing bit is enabled by defining PARITY_CHECK_EN.
module serial_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   input  logic             sv,
   input  logic             dir,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ack,
   output logic             busy,
   output logic             ovr,
   input  logic             clr_ovr,
   output logic             perr
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             qv_q, qv_d;
   logic             ovr_q, ovr_d;
   logic [WIDTH-1:0] base, shifted, word;
   logic             commit, ovr_set, ack_eff;
`ifdef PARITY_CHECK_EN
   logic             perr_q, perr_d, perr_set;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         qv_q    <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         qv_q    <= qv_d;
         ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      qv_d    = qv_q;
      commit  = 1'b0;
      ovr_set = 1'b0;
`ifdef PARITY_CHECK_EN
      perr_set = 1'b0;
`endif
      // A restart empties the register so a coincident bit is the only one held
      base    = start ? '0 : sr_q;
      shifted = dir ? {si, base[WIDTH-1:1]} : {base[WIDTH-2:0], si};
      word    = shifted;
      ack_eff = q_ack & qv_q;

      if (start) begin
         state_d = IDLE;
         cnt_d   = '0;
         if (sv) begin
            sr_d    = shifted;
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
         end
      end else if (sv) begin
         case (state_q)
            IDLE: begin
               sr_d    = shifted;
               cnt_d   = CNT_W'(1);
               state_d = SHIFT;
            end
            SHIFT: begin
               sr_d = shifted;
               if (cnt_q == LAST) begin
                  cnt_d = '0;
`ifdef PARITY_CHECK_EN
                  state_d = PAR;
`else
                  commit  = 1'b1;
                  state_d = IDLE;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
`ifdef PARITY_CHECK_EN
            PAR: begin
               state_d = IDLE;
               word    = sr_q;
               if (^{sr_q, si}) perr_set = 1'b1;
               else             commit   = 1'b1;
            end
`endif
            default: state_d = IDLE;
         endcase
      end

      if (commit) begin
         if (!qv_q || ack_eff) begin
            q_d  = word;
            qv_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (ack_eff) begin
         qv_d = 1'b0;
      end

      ovr_d = ovr_set | (ovr_q & ~clr_ovr);
`ifdef PARITY_CHECK_EN
      perr_d = perr_set | (perr_q & ~clr_ovr);
`endif
   end

   assign q       = q_q;
   assign q_valid = qv_q;
   assign busy    = (state_q != IDLE);
   assign ovr     = ovr_q;
`ifdef PARITY_CHECK_EN
   assign perr    = perr_q;
`else
   assign perr    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: framing, both shift directions, gaps, overrun, restart, reset and optional parity.
module tb_serial_deserializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, si, sv, dir, start, q_ack, clr_ovr;
   logic [W-1:0] q;
   logic         q_valid, busy, ovr, perr;
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   serial_deserializer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .si(si), .sv(sv), .dir(dir), .start(start),
      .q(q), .q_valid(q_valid), .q_ack(q_ack), .busy(busy),
      .ovr(ovr), .clr_ovr(clr_ovr), .perr(perr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic send(input logic b);
      sv = 1'b1;
      si = b;
      step();
      sv = 1'b0;
      si = 1'b0;
   endtask

   task automatic ack();
      q_ack = 1'b1;
      step();
      q_ack = 1'b0;
   endtask

   // seq is the bit order on the line, MSB first; gap<0 means i%6 idle cycles after bit i
   task automatic frame(input logic [7:0] seq, input logic d, input int gap,
                        input logic ack_l, input logic clr_l);
      dir = d;
      for (int i = 0; i < 8; i++) begin
`ifndef PARITY_CHECK_EN
         if (i == 7) begin
            q_ack   = ack_l;
            clr_ovr = clr_l;
         end
`endif
         send(seq[7-i]);
         q_ack   = 1'b0;
         clr_ovr = 1'b0;
         if (i == 0) check("busy_first", busy, 1);
         if (i < 7) begin
            repeat ((gap < 0) ? (i % 6) : gap) step();
            if (gap < 0) check("busy_gap", busy, 1);
         end
      end
`ifdef PARITY_CHECK_EN
      q_ack   = ack_l;
      clr_ovr = clr_l;
      send(^seq);
      q_ack   = 1'b0;
      clr_ovr = 1'b0;
`endif
   endtask

   initial begin
      rst = 1'b1; si = 1'b0; sv = 1'b0; dir = 1'b0; start = 1'b0;
      q_ack = 1'b0; clr_ovr = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();
      check("rst_q", q, 0);
      check("rst_qv", q_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", ovr, 0);
      check("rst_perr", perr, 0);

      // basic frame, dir=0
      dir = 1'b0;
      for (int i = 0; i < 7; i++) send(((8'hB2 >> (7 - i)) & 8'h01) != 0);
      check("pre_commit_qv", q_valid, 0);
      check("pre_commit_busy", busy, 1);
      send(1'b0);
`ifdef PARITY_CHECK_EN
      send(^8'hB2);
`endif
      check("b2_q", q, 32'hB2);
      check("b2_qv", q_valid, 1);
      check("b2_busy", busy, 0);
      ack();
      check("ack_qv", q_valid, 0);
      check("ack_q_hold", q, 32'hB2);
      ack();
      check("ack_idle_qv", q_valid, 0);

      // dir=1 reverses placement
      frame(8'hB2, 1'b1, 0, 1'b0, 1'b0);
      check("4d_q", q, 32'h4D);
      check("4d_qv", q_valid, 1);
      ack();

      // gaps between strobes
      frame(8'hB2, 1'b0, -1, 1'b0, 1'b0);
      check("gap_q", q, 32'hB2);
      check("gap_busy", busy, 0);
      ack();

      // overrun and collision handling
      frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
      frame(8'h22, 1'b0, 1, 1'b0, 1'b0);
      check("ovr_q", q, 32'h11);
      check("ovr_flag", ovr, 1);
      check("ovr_qv", q_valid, 1);
      ack();
      check("ovr_ack_qv", q_valid, 0);
      check("ovr_sticky", ovr, 1);
      clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
      check("ovr_clr", ovr, 0);
      frame(8'h44, 1'b0, 0, 1'b0, 1'b0);
      frame(8'h33, 1'b0, 0, 1'b1, 1'b0);
      check("coll_q", q, 32'h33);
      check("coll_qv", q_valid, 1);
      check("coll_ovr", ovr, 0);
      frame(8'h55, 1'b0, 0, 1'b0, 1'b1);
      check("setwins_ovr", ovr, 1);
      check("setwins_q", q, 32'h33);
      clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
      check("setwins_clr", ovr, 0);
      ack();

      // restart discards partial bits
      dir = 1'b0;
      send(1'b0); send(1'b1); send(1'b0);
      start = 1'b1; step(); start = 1'b0;
      check("start_busy", busy, 0);
      frame(8'hFF, 1'b0, 0, 1'b0, 1'b0);
      check("start_q", q, 32'hFF);
      ack();

      // restart coincident with the final bit: no commit, bit begins a new frame
      for (int i = 0; i < 7; i++) send(1'b0);
      start = 1'b1; send(1'b1); start = 1'b0;
      check("start8_qv", q_valid, 0);
      check("start8_busy", busy, 1);
      for (int i = 0; i < 7; i++) send(i[0]);
`ifdef PARITY_CHECK_EN
      send(^8'hAA);
`endif
      check("start8_q", q, 32'hAA);
      check("start8_qv2", q_valid, 1);

      // asynchronous reset mid-frame
      frame(8'h77, 1'b0, 0, 1'b0, 1'b0);
      check("pre_rst_ovr", ovr, 1);
      send(1'b1); send(1'b1); send(1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_q", q, 0);
      check("arst_qv", q_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_ovr", ovr, 0);
      @(negedge clk) rst = 1'b0;
      frame(8'hB2, 1'b0, 0, 1'b0, 1'b0);
      check("post_rst_q", q, 32'hB2);
      check("post_rst_ovr", ovr, 0);
      ack();

`ifdef PARITY_CHECK_EN
      frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
      check("par_ok_q", q, 32'hA5);
      check("par_ok_qv", q_valid, 1);
      check("par_ok_perr", perr, 0);
      dir = 1'b0;
      for (int i = 0; i < 8; i++) send(((8'hA5 >> (7 - i)) & 8'h01) != 0);
      check("par_busy", busy, 1);
      send(1'b1);
      check("par_bad_perr", perr, 1);
      check("par_bad_qv", q_valid, 1);
      check("par_bad_ovr", ovr, 0);
      clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
      check("par_clr", perr, 0);
`else
      check("perr_tied", perr, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
